// File: rtl/key_debounce_ctrl.sv
`timescale 1ns/1ps
// key_debounce_ctrl: N-channel active-low key front end. Each key is
// synchronised, then debounced by its own state machine. Each channel reports
// a debounced level plus press, release and long-press pulses. A toggle LED
// per key is cleared by a long press on any channel.
module key_debounce_ctrl #(
    parameter int N_KEY       = 4,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_KEY-1:0] key,
    output logic [N_KEY-1:0] key_state,
    output logic [N_KEY-1:0] press_pulse,
    output logic [N_KEY-1:0] release_pulse,
    output logic [N_KEY-1:0] long_pulse,
    output logic [N_KEY-1:0] led
);

    // Terminal counts for the debounce window and the long-press timer.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    logic [N_KEY-1:0] sync_p0;
    logic [N_KEY-1:0] sync_p1;

    // Stage p0 -> p1: two-flop synchroniser. Both flops idle at 1 (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= key;
            sync_p1 <= sync_p0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_KEY; gi++) begin : g_ch
            state_t           state_q;
            state_t           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             long_done_q;
            logic             long_done_d;
            logic             level_q;
            logic             level_d;
            logic             press_q;
            logic             press_d;
            logic             rel_q;
            logic             rel_d;
            logic             long_q;
            logic             long_d;
            logic             s;

            // s is the synchronised raw key, 0 = pressed.
            assign s = sync_p1[gi];

            // Channel state register, counter, long-press flag and registered events.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    long_done_q <= 1'b0;
                    level_q     <= 1'b0;
                    press_q     <= 1'b0;
                    rel_q       <= 1'b0;
                    long_q      <= 1'b0;
                end else begin
                    state_q     <= state_d;
                    cnt_q       <= cnt_d;
                    long_done_q <= long_done_d;
                    level_q     <= level_d;
                    press_q     <= press_d;
                    rel_q       <= rel_d;
                    long_q      <= long_d;
                end
            end

            // Next-state decode: debounce both edges, time the long press once per press.
            always_comb begin
                state_d     = state_q;
                cnt_d       = cnt_q;
                long_done_d = long_done_q;
                level_d     = level_q;
                press_d     = 1'b0;
                rel_d       = 1'b0;
                long_d      = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (!s) begin
                            state_d = DEB_PRESS;
                            cnt_d   = '0;
                        end
                    end
                    DEB_PRESS: begin
                        if (s) begin
                            state_d = IDLE;
                        end else if (cnt_q == DEB_LAST) begin
                            state_d     = HELD;
                            cnt_d       = '0;
                            long_done_d = 1'b0;
                            press_d     = 1'b1;
                            level_d     = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (s) begin
                            state_d = DEB_REL;
                            cnt_d   = '0;
                        end else if (cnt_q == LONG_LAST && !long_done_q) begin
                            long_d      = 1'b1;
                            long_done_d = 1'b1;
                        end else if (cnt_q < LONG_LAST) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    DEB_REL: begin
                        // A bounce back to low restarts the long timer but keeps
                        // long_done, so one press never fires twice.
                        if (!s) begin
                            state_d = HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            rel_d   = 1'b1;
                            level_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign key_state[gi]     = level_q;
            assign press_pulse[gi]   = press_q;
            assign release_pulse[gi] = rel_q;
            assign long_pulse[gi]    = long_q;
        end
    endgenerate

    // LED toggle: a long press anywhere clears all LEDs first, then presses toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else begin
            led <= ((|long_pulse) ? '0 : led) ^ press_pulse;
        end
    end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
`timescale 1ns/1ps
// Bench for key_debounce_ctrl with N_KEY=4, DEB_CYCLES=4, LONG_CYCLES=20.
// A run-length behavioural model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_key_debounce_ctrl;

    localparam int N    = 4;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    localparam int F_PRESS = 0;
    localparam int F_REL   = 1;
    localparam int F_LONG  = 2;
    localparam int F_STATE = 3;
    localparam int F_LED   = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] key;
    logic [N-1:0] key_state;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_pulse;
    logic [N-1:0] led;

    key_debounce_ctrl #(
        .N_KEY      (N),
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key          (key),
        .key_state    (key_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .led          (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_s1, m_s2;
    logic [N-1:0] m_lvl, m_press, m_rel, m_long, m_led, m_high, m_ldone;
    int           m_run[N];
    int           m_restart[N];
    int           m_edge;

    task automatic m_reset();
        m_s1 = '1; m_s2 = '1;
        m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0; m_led = '0;
        m_high = '0; m_ldone = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_restart[i] = 0;
        end
    endtask

    task automatic m_step();
        logic [N-1:0] obs, np, nr, nl;
        logic p;
        obs = m_s2;
        np = '0; nr = '0; nl = '0;
        m_led = ((m_long != '0) ? '0 : m_led) ^ m_press;
        for (int i = 0; i < N; i++) begin
            p = ~obs[i];
            if (p != m_lvl[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == DEB + 1) begin
                m_run[i] = 0;
                if (p) begin
                    np[i] = 1'b1; m_lvl[i] = 1'b1;
                    m_restart[i] = m_edge; m_high[i] = 1'b0; m_ldone[i] = 1'b0;
                end else begin
                    nr[i] = 1'b1; m_lvl[i] = 1'b0;
                end
            end else if (m_lvl[i]) begin
                if (!p) begin
                    m_high[i] = 1'b1;
                end else if (m_high[i]) begin
                    m_restart[i] = m_edge; m_high[i] = 1'b0;
                end else if ((m_edge - m_restart[i]) == LONG && !m_ldone[i]) begin
                    nl[i] = 1'b1; m_ldone[i] = 1'b1;
                end
            end
        end
        m_press = np; m_rel = nr; m_long = nl;
        m_s2 = m_s1; m_s1 = key;
        m_edge++;
    endtask

    initial begin
        m_edge = 0;
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // ---------------- literal expectation table ----------------
    string        lit_name[256];
    int           lit_field[256];
    logic [N-1:0] lit_val[256];
    int           lit_wr = 0;

    function automatic logic [N-1:0] dut_field(int f);
        case (f)
            F_PRESS: return press_pulse;
            F_REL:   return release_pulse;
            F_LONG:  return long_pulse;
            F_STATE: return key_state;
            default: return led;
        endcase
    endfunction

    function automatic logic [N-1:0] model_field(int f);
        case (f)
            F_PRESS: return m_press;
            F_REL:   return m_rel;
            F_LONG:  return m_long;
            F_STATE: return m_lvl;
            default: return m_led;
        endcase
    endfunction

    // ---------------- compare process ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int lit_rd = 0;

    task automatic cmp(string name, logic [N-1:0] act, logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp("model_key_state", key_state, m_lvl);
            cmp("model_press", press_pulse, m_press);
            cmp("model_release", release_pulse, m_rel);
            cmp("model_long", long_pulse, m_long);
            cmp("model_led", led, m_led);
            while (lit_rd < lit_wr) begin
                cmp(lit_name[lit_rd], dut_field(lit_field[lit_rd]), lit_val[lit_rd]);
                cmp({lit_name[lit_rd], "_model"}, model_field(lit_field[lit_rd]), lit_val[lit_rd]);
                lit_rd++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(string name, int f, logic [N-1:0] v);
        lit_name[lit_wr]  = name;
        lit_field[lit_wr] = f;
        lit_val[lit_wr]   = v;
        lit_wr++;
    endtask

    task automatic tap(int ch);
        logic [N-1:0] b;
        b = 4'b0001 << ch;
        key[ch] = 1'b0;
        tick(7);
        expect_v("tap_press", F_PRESS, b);
        tick(1);
        key[ch] = 1'b1;
        tick(7);
        expect_v("tap_release", F_REL, b);
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0;
        key   = '1;
        tick(3);
        expect_v("reset_led", F_LED, 4'b0000);
        expect_v("reset_state", F_STATE, 4'b0000);
        expect_v("reset_press", F_PRESS, 4'b0000);
        rst_n = 1'b1;
        tick(3);

        // Clean press and release on key 0
        key[0] = 1'b0;
        tick(6);
        expect_v("clean_early", F_PRESS, 4'b0000);
        tick(1);
        expect_v("clean_press", F_PRESS, 4'b0001);
        expect_v("clean_state", F_STATE, 4'b0001);
        expect_v("clean_led_pre", F_LED, 4'b0000);
        tick(1);
        expect_v("clean_press_end", F_PRESS, 4'b0000);
        expect_v("clean_led", F_LED, 4'b0001);
        key[0] = 1'b1;
        tick(7);
        expect_v("clean_release", F_REL, 4'b0001);
        expect_v("clean_state_rel", F_STATE, 4'b0000);
        tick(1);
        expect_v("clean_release_end", F_REL, 4'b0000);

        // Press bounce on key 1: 3 low, 2 high, then held low
        key[1] = 1'b0;
        tick(3);
        key[1] = 1'b1;
        tick(2);
        key[1] = 1'b0;
        tick(6);
        expect_v("bounce_early", F_PRESS, 4'b0000);
        expect_v("bounce_state_early", F_STATE, 4'b0000);
        tick(1);
        expect_v("bounce_press", F_PRESS, 4'b0010);
        tick(1);
        expect_v("bounce_led", F_LED, 4'b0011);
        key[1] = 1'b1;
        tick(7);
        expect_v("bounce_release", F_REL, 4'b0010);
        tick(1);

        // Long press on key 2 starting from led=0101
        tap(1);
        expect_v("long_led_base", F_LED, 4'b0001);
        key[2] = 1'b0;
        tick(7);
        expect_v("long_press", F_PRESS, 4'b0100);
        tick(1);
        expect_v("long_led_before", F_LED, 4'b0101);
        tick(18);
        expect_v("long_early", F_LONG, 4'b0000);
        tick(1);
        expect_v("long_pulse", F_LONG, 4'b0100);
        expect_v("long_led_same", F_LED, 4'b0101);
        tick(1);
        expect_v("long_pulse_end", F_LONG, 4'b0000);
        expect_v("long_led_clear", F_LED, 4'b0000);
        tick(80);
        expect_v("long_still_held", F_STATE, 4'b0100);
        expect_v("long_led_after", F_LED, 4'b0000);
        key[2] = 1'b1;
        tick(7);
        expect_v("long_release", F_REL, 4'b0100);
        tick(1);

        // Simultaneous press on keys 0 and 3, then release with a bounce on key 3
        key[0] = 1'b0;
        key[3] = 1'b0;
        tick(7);
        expect_v("simul_press", F_PRESS, 4'b1001);
        expect_v("simul_state", F_STATE, 4'b1001);
        tick(1);
        expect_v("simul_led", F_LED, 4'b1001);
        key[0] = 1'b1;
        key[3] = 1'b1;
        tick(2);
        key[3] = 1'b0;
        tick(2);
        key[3] = 1'b1;
        tick(3);
        expect_v("rb_release0", F_REL, 4'b0001);
        expect_v("rb_state0", F_STATE, 4'b1000);
        tick(3);
        expect_v("rb_no_early", F_REL, 4'b0000);
        expect_v("rb_state_held", F_STATE, 4'b1000);
        tick(1);
        expect_v("rb_release3", F_REL, 4'b1000);
        expect_v("rb_state_fall", F_STATE, 4'b0000);
        expect_v("rb_no_press", F_PRESS, 4'b0000);
        tick(1);
        expect_v("rb_release_end", F_REL, 4'b0000);
        expect_v("rb_led", F_LED, 4'b1001);

        // long_pulse[1] in the same cycle as press_pulse[0]
        key[1] = 1'b0;
        tick(7);
        expect_v("align_press1", F_PRESS, 4'b0010);
        tick(1);
        expect_v("align_led_pre", F_LED, 4'b1011);
        tick(12);
        key[0] = 1'b0;
        tick(7);
        expect_v("align_long1", F_LONG, 4'b0010);
        expect_v("align_press0", F_PRESS, 4'b0001);
        tick(1);
        expect_v("align_led", F_LED, 4'b0001);
        key[0] = 1'b1;
        key[1] = 1'b1;
        tick(7);
        expect_v("align_release", F_REL, 4'b0011);
        tick(1);

        // Reset while key 0 is held and key 1 is mid-debounce, led=1111
        tap(0);
        tap(1);
        tap(2);
        tap(3);
        expect_v("pre_reset_led_base", F_LED, 4'b1110);
        key[0] = 1'b0;
        tick(7);
        expect_v("pre_reset_press", F_PRESS, 4'b0001);
        tick(1);
        expect_v("pre_reset_led", F_LED, 4'b1111);
        key[1] = 1'b0;
        tick(4);
        rst_n = 1'b0;
        expect_v("rst_led", F_LED, 4'b0000);
        expect_v("rst_state", F_STATE, 4'b0000);
        expect_v("rst_press", F_PRESS, 4'b0000);
        expect_v("rst_release", F_REL, 4'b0000);
        expect_v("rst_long", F_LONG, 4'b0000);
        tick(3);
        expect_v("rst_hold_led", F_LED, 4'b0000);
        rst_n = 1'b1;
        tick(6);
        expect_v("post_rst_early", F_PRESS, 4'b0000);
        tick(1);
        expect_v("post_rst_press", F_PRESS, 4'b0011);
        expect_v("post_rst_state", F_STATE, 4'b0011);
        tick(1);
        expect_v("post_rst_led", F_LED, 4'b0011);
        key = '1;
        tick(10);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
